// File: rtl/lasso_support_scan.sv
// Post-solver support scan: snapshots xhat, streams elements whose magnitude
// exceeds a threshold as (index, value) pairs, and tracks nnz and max |x|.
module lasso_support_scan #(
  parameter  int J  = 240,
  parameter  int Q  = 7,
  parameter  int N  = 16,
  localparam int IW = $clog2(J),
  localparam int CW = $clog2(J+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [0:J-1][N-1:0]     xhat,
  input  logic [N-1:0]            thresh,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           out_idx,
  output logic [N-1:0]            out_val,
  output logic [CW-1:0]           nnz,
  output logic [N-2:0]            max_abs,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t              state, state_n;
  logic [0:J-1][N-1:0] snap;
  logic [IW-1:0]       i, i_n;
  logic                out_valid_n, busy_n, done_n;
  logic [IW-1:0]       out_idx_n;
  logic [N-1:0]        out_val_n;
  logic [CW-1:0]       nnz_n;
  logic [N-2:0]        max_n;
  logic [N-2:0]        mag_cur;
  logic                qual, last;

  // Q only describes the fixed-point format; the sign bit of thresh is ignored.
  logic unused_ok;
  assign unused_ok = ^{thresh[N-1], Q[0]};

  assign mag_cur = snap[i][N-2:0];
  assign qual    = mag_cur > thresh[N-2:0];
  assign last    = (i == IW'(J-1));

  always_comb begin
    state_n     = state;
    i_n         = i;
    out_valid_n = out_valid;
    out_idx_n   = out_idx;
    out_val_n   = out_val;
    nnz_n       = nnz;
    max_n       = max_abs;
    busy_n      = busy;
    done_n      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = SCAN;
        i_n     = '0;
        nnz_n   = '0;
        max_n   = '0;
        busy_n  = 1'b1;
      end
      SCAN: begin
        if (mag_cur > max_abs) max_n = mag_cur;
        if (qual) begin
          out_idx_n   = i;
          out_val_n   = snap[i];
          out_valid_n = 1'b1;
          nnz_n       = nnz + CW'(1);
          state_n     = EMIT;
        end else if (!last) begin
          i_n = i + IW'(1);
        end else begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      EMIT: if (out_ready) begin
        out_valid_n = 1'b0;
        if (!last) begin
          i_n     = i + IW'(1);
          state_n = SCAN;
        end else begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_val   <= '0;
      nnz       <= '0;
      max_abs   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      i         <= i_n;
      out_valid <= out_valid_n;
      out_idx   <= out_idx_n;
      out_val   <= out_val_n;
      nnz       <= nnz_n;
      max_abs   <= max_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Snapshot is taken only on an accepted start; later xhat changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      snap <= '0;
    else if (state == IDLE && start) snap <= xhat;
  end

endmodule

// File: doc/lasso_support_scan.md
# lasso_support_scan

Downstream stage of the LASSO solver. After the solver asserts `done`, this block snapshots the solution vector `xhat` and scans it once. It streams every element whose magnitude strictly exceeds a programmable threshold as an (index, value) pair over a valid/ready interface. It also reports the support size (`nnz`) and the largest magnitude seen.

## Interface
Parameters:
- `J`, 240, length of `xhat`
- `Q`, 7, fractional bits (carried only; arithmetic is comparisons)
- `N`, 16, word width
- `IW`, `$clog2(J)`, local parameter, index width
- `CW`, `$clog2(J+1)`, local parameter, count width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin scan; sampled only in IDLE
- `xhat`  in  N x [0:J-1]  solver solution vector, sign-magnitude
- `thresh`  in  N  magnitude threshold; sign bit ignored
- `out_valid`  out  1  output pair valid
- `out_ready`  in  1  consumer accepts pair
- `out_idx`  out  IW  index of emitted element
- `out_val`  out  N  emitted element, unmodified snapshot value
- `nnz`  out  CW  number of emitted elements in last/current scan
- `max_abs`  out  N-1  largest magnitude among all J elements
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse at scan completion

## Operation
- Number format: sign-magnitude; bit N-1 is the sign, bits N-2:0 are the magnitude. Negative zero counts as magnitude 0.
- Qualify rule: `mag(snap[i]) > mag(thresh)`, unsigned compare on N-1 bits. Equality does not qualify.
- States:
  - IDLE -> SCAN on `start`. On the same edge: snapshot `xhat` into an internal array; set `i`=0; clear `nnz` and `max_abs`; set `busy`=1.
  - SCAN: examines `snap[i]`. `max_abs` is updated with `mag(snap[i])` if that value is larger.
    - If it qualifies: register `out_idx`=i and `out_val`=`snap[i]`, set `out_valid`=1, increment `nnz`, go to EMIT.
    - If it does not qualify and i<J-1: i++ and stay in SCAN.
    - If it does not qualify and i==J-1: `done`<=1, `busy`<=0, go to IDLE.
  - EMIT: hold `out_valid`, `out_idx` and `out_val` stable until `out_ready` is sampled high. On that edge `out_valid`<=0, then:
    - if i<J-1: i++ and go to SCAN;
    - otherwise: `done`<=1, `busy`<=0, go to IDLE.
- `start` outside IDLE is ignored. Changes to `xhat` after the snapshot have no effect.
- `nnz` and `max_abs` hold their values after `done` until the next accepted `start`.
- Pairs are emitted in strictly ascending index order, and there is exactly one transfer per qualifying element.

## Timing
- Reset values: `out_valid`=0, `out_idx`=0, `out_val`=0, `nnz`=0, `max_abs`=0, `busy`=0, `done`=0, state IDLE, snapshot cleared.
- Reset asserted mid-scan: aborts immediately, all outputs return to reset values, and no `done` pulse is produced.
- The `start` sampling edge is edge 0. Index i is evaluated in the cycle after edge i (when there are no stalls).
- A non-qualifying element costs 1 cycle. A qualifying element costs 1 + (cycles until `out_ready` is sampled high); with `out_ready` tied to 1 that is 2 cycles.
- Total latency from `start` edge to the edge that raises `done` is J + nnz with `out_ready`=1, plus one extra cycle per stall cycle.
- `done` is high for exactly one cycle and coincides with `busy` falling. `start` may be accepted on the cycle `done` is high, since the state is IDLE.
- `out_valid` never deasserts without a handshake, and its payload never changes while valid.

## Test plan
- J=8, `xhat` all zero, `thresh`=0, `out_ready`=1 -> no transfers; `done` high 8 cycles after the `start` edge; `nnz`=0; `max_abs`=0.
- J=8, `xhat`={0,0x0105,0,0x8200,0,0,0,0x0003}, `thresh`=0x0004, `out_ready`=1 -> pairs (1,0x0105) then (3,0x8200); `nnz`=2; `max_abs`=0x0200; `done` 10 cycles after `start`.
- Same vector with `thresh`=0x0105 -> only (3,0x8200) is emitted, since equality does not qualify; `nnz`=1.
- Same vector as test 2, `out_ready` held low for 5 cycles on the first pair -> `out_valid`, `out_idx`=1 and `out_val`=0x0105 stay stable throughout the stall; `done` arrives 5 cycles later than in test 2.
- `xhat[7]`=0x8000 (negative zero) with `thresh`=0 -> not emitted. `xhat[7]`=0x0001 -> emitted as the final pair, and `done` follows on the handshake edge.
- Assert `rst_n` low while in EMIT -> all outputs go to 0 immediately and no `done` pulse occurs. A new `start` after release produces a correct full scan.
